mask_compositor: RTL and testbench
==================================

// Module: mask_compositor
// PURPOSE
//  Consumes the in-order 1-bit mask stream from the mask multiplexer and the raw RGB pixel stream.
//  Buffers RGB pixels until their mask arrives, then emits the pixel (mask=1, foreground) or
//  i_BG_COLOR (mask=0). Tracks raster position and flags line/frame boundaries.
//  Final stage of background removal, ahead of the output/video writer.
// PARAMETERS
//  DATA_WIDTH  24   pixel width, {R[23:16],G[15:8],B[7:0]}
//  FIFO_DEPTH  64   RGB alignment FIFO entries, power of 2; must cover worst-case mask latency
//  IMG_WIDTH   640  pixels per line
//  IMG_HEIGHT  480  lines per frame
// PORTS
//  i_CLK        in   1           clock, rising edge
//  i_RSTn       in   1           asynchronous active-low reset
//  i_VALID      in   1           RGB pixel strobe, same stream feeding the mask path
//  i_DATA       in   DATA_WIDTH  RGB pixel
//  i_MASK_VALID in   1           mask strobe, pixel order
//  i_MASK       in   1           1 = foreground, 0 = background
//  i_BG_COLOR   in   DATA_WIDTH  replacement colour, sampled on each pop
//  i_ERR_CLR    in   1           synchronous clear of sticky error flags
//  o_VALID      out  1           output pixel strobe
//  o_DATA       out  DATA_WIDTH  composited pixel
//  o_SOL        out  1           with o_VALID: column 0
//  o_EOL        out  1           with o_VALID: column IMG_WIDTH-1
//  o_EOF        out  1           with o_VALID: last pixel of frame
//  o_ERR_OVF    out  1           sticky: pixel dropped, FIFO full
//  o_ERR_UNF    out  1           sticky: mask arrived with FIFO empty
//  o_FG_COUNT   out  $clog2(IMG_WIDTH*IMG_HEIGHT+1)  foreground pixels in last frame
// BEHAVIOUR
//  - Reset: all outputs 0, FIFO empty, col/row counters 0, FG counters 0.
//  - Push: i_VALID && !full -> write i_DATA. i_VALID && full -> drop pixel, set o_ERR_OVF.
//  - Pop: i_MASK_VALID && !empty. Empty is evaluated on the pre-write count, so a push in the
//    same cycle does not satisfy the pop. i_MASK_VALID && empty -> drop mask, set o_ERR_UNF.
//  - Push and pop in the same cycle with the FIFO non-empty and not full: both happen, count
//    unchanged. Push into a full FIFO is dropped even if a pop occurs that cycle.
//  - Latency: pop at cycle N -> o_VALID=1 at N+1, o_DATA = mask ? fifo_head : i_BG_COLOR(N).
//    All outputs registered. o_VALID is a one-cycle pulse per pop. No backpressure.
//  - Raster counters col/row advance on each output pixel:
//    col==IMG_WIDTH-1 -> col=0, row++; row==IMG_HEIGHT-1 && EOL -> row=0, o_EOF=1.
//  - o_SOL/o_EOL/o_EOF are valid only when o_VALID=1; 0 otherwise.
//  - Error flags: sticky until i_ERR_CLR. If i_ERR_CLR and a new error occur in the same cycle,
//    the set wins. Errors do not alter counters.
//  - Async reset mid-frame: FIFO is flushed and counters restart at (0,0). Upstream must also
//    restart at frame start.
// CONFIGURATION
//  - FG_COUNT_EN defined: a running counter increments on each output with mask=1, including
//    the EOF pixel. On EOF the counter value is latched into o_FG_COUNT and the counter
//    restarts at 0.
//  - FG_COUNT_EN undefined: no counter logic; o_FG_COUNT tied to 0.
// STRUCTURE
//  - Package bgr_pkg: typedef pixel_t (logic[23:0]), RGB field localparams,
//    DEF_IMG_WIDTH/DEF_IMG_HEIGHT, BG colour constant BG_BLACK=24'h000000.
//  - Sub-module pixel_align_fifo: synchronous FIFO, first-word-fall-through, parameters
//    DATA_WIDTH/DEPTH. Ports: wr_en, wr_data, rd_en, rd_data, full, empty.
//    Pointers carry one extra bit for full/empty detection.
//  - Top level: pop/error logic, output register, raster counters, optional FG counter.
// TESTING (IMG_WIDTH=4, IMG_HEIGHT=2, FIFO_DEPTH=8 on bench)
//  1. 8 pixels 24'h000001..8, masks 1,0,1,0,1,0,1,0 each 3 cycles after their pixel,
//     BG=24'hFFFFFF -> outputs 1,FFFFFF,3,FFFFFF,5,FFFFFF,7,FFFFFF; SOL on #1,#5; EOL on #4,#8;
//     EOF on #8.
//  2. Push 9 pixels with no masks -> o_ERR_OVF=1 on the 9th. Then 8 masks -> pixels 1..8 out.
//     Pixel 9 is never output.
//  3. Mask with FIFO empty -> o_ERR_UNF=1, no o_VALID. i_ERR_CLR pulse -> flag 0 next cycle.
//  4. Continuous push and pop every cycle, lag 1, 16 pixels -> 16 outputs, 2 EOFs,
//     count stays 1.
//  5. Assert i_RSTn=0 after output pixel 3 -> all outputs 0 immediately. After release,
//     a new frame starts with SOL on the first pixel.
//  6. FG_COUNT_EN defined, frame of 5 foreground and 3 background pixels -> o_FG_COUNT=5 one
//     cycle after EOF. Next frame all foreground -> 8.

Source files
------------

// File: rtl/bgr_pkg.sv
// Shared types and constants for the background-removal pixel path.
package bgr_pkg;

  typedef logic [23:0] pixel_t;

  // RGB field positions inside a packed pixel
  localparam int R_MSB = 23;
  localparam int R_LSB = 16;
  localparam int G_MSB = 15;
  localparam int G_LSB = 8;
  localparam int B_MSB = 7;
  localparam int B_LSB = 0;

  localparam int DEF_IMG_WIDTH  = 640;
  localparam int DEF_IMG_HEIGHT = 480;

  localparam pixel_t BG_BLACK = 24'h000000;

endpackage

// File: rtl/pixel_align_fifo.sv
// First-word-fall-through FIFO that holds RGB pixels while their mask is
// still in flight. Pointers carry one extra wrap bit so full and empty can
// be told apart when the address bits match.
module pixel_align_fifo
  import bgr_pkg::*;
#(
  parameter int DATA_WIDTH = 24,
  parameter int DEPTH      = 64
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  wr_en,
  input  logic [DATA_WIDTH-1:0] wr_data,
  input  logic                  rd_en,
  output logic [DATA_WIDTH-1:0] rd_data,
  output logic                  full,
  output logic                  empty
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [DATA_WIDTH-1:0] mem [DEPTH];
  logic [AW:0]           wr_ptr;
  logic [AW:0]           rd_ptr;
  logic                  do_wr;
  logic                  do_rd;

  assign empty   = (wr_ptr == rd_ptr);
  assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign do_wr   = wr_en && !full;
  assign do_rd   = rd_en && !empty;
  // Head of queue is always presented, so a pop consumes the word already shown
  assign rd_data = mem[rd_ptr[AW-1:0]];

  // Pointer update; flushing on reset discards any buffered pixels
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (do_wr) wr_ptr <= wr_ptr + 1'b1;
      if (do_rd) rd_ptr <= rd_ptr + 1'b1;
    end
  end

  // Storage array carries data only, so it needs no reset
  always_ff @(posedge clk) begin
    if (do_wr) mem[wr_ptr[AW-1:0]] <= wr_data;
  end

endmodule

// File: rtl/mask_compositor.sv
// Final stage of background removal: pairs each buffered RGB pixel with its
// late-arriving 1-bit mask and emits either the pixel (foreground) or the
// background colour, tagged with raster start/end-of-line and end-of-frame.
// Optional feature macro: FG_COUNT_EN -- when defined, counts foreground
// pixels per frame and publishes the total on o_FG_COUNT at each EOF;
// otherwise o_FG_COUNT is tied to zero.
module mask_compositor
  import bgr_pkg::*;
#(
  parameter int DATA_WIDTH = 24,
  parameter int FIFO_DEPTH = 64,
  parameter int IMG_WIDTH  = DEF_IMG_WIDTH,
  parameter int IMG_HEIGHT = DEF_IMG_HEIGHT
) (
  input  logic                  i_CLK,
  input  logic                  i_RSTn,
  input  logic                  i_VALID,
  input  logic [DATA_WIDTH-1:0] i_DATA,
  input  logic                  i_MASK_VALID,
  input  logic                  i_MASK,
  input  logic [DATA_WIDTH-1:0] i_BG_COLOR,
  input  logic                  i_ERR_CLR,
  output logic                  o_VALID,
  output logic [DATA_WIDTH-1:0] o_DATA,
  output logic                  o_SOL,
  output logic                  o_EOL,
  output logic                  o_EOF,
  output logic                  o_ERR_OVF,
  output logic                  o_ERR_UNF,
  output logic [$clog2(IMG_WIDTH*IMG_HEIGHT+1)-1:0] o_FG_COUNT
);

  localparam int COL_W = (IMG_WIDTH  > 1) ? $clog2(IMG_WIDTH)  : 1;
  localparam int ROW_W = (IMG_HEIGHT > 1) ? $clog2(IMG_HEIGHT) : 1;
  localparam logic [COL_W-1:0] COL_LAST = COL_W'(IMG_WIDTH - 1);
  localparam logic [ROW_W-1:0] ROW_LAST = ROW_W'(IMG_HEIGHT - 1);

  // Foreground keeps the camera pixel, background takes the replacement colour
  function automatic logic [DATA_WIDTH-1:0] composite(
    input logic                  fg,
    input logic [DATA_WIDTH-1:0] pix,
    input logic [DATA_WIDTH-1:0] bg
  );
    return fg ? pix : bg;
  endfunction

  logic                  fifo_full_p0;
  logic                  fifo_empty_p0;
  logic [DATA_WIDTH-1:0] head_p0;
  logic                  push_p0;
  logic                  pop_p0;
  logic                  ovf_evt_p0;
  logic                  unf_evt_p0;
  logic [COL_W-1:0]      col_p0;
  logic [ROW_W-1:0]      row_p0;
  logic                  col_last_p0;
  logic                  row_last_p0;
  logic                  eof_p0;

  // ---- stage p0: FIFO occupancy decides push/pop against pre-write state ----
  assign push_p0     = i_VALID && !fifo_full_p0;
  assign ovf_evt_p0  = i_VALID && fifo_full_p0;
  assign pop_p0      = i_MASK_VALID && !fifo_empty_p0;
  assign unf_evt_p0  = i_MASK_VALID && fifo_empty_p0;
  assign col_last_p0 = (col_p0 == COL_LAST);
  assign row_last_p0 = (row_p0 == ROW_LAST);
  assign eof_p0      = pop_p0 && col_last_p0 && row_last_p0;

  pixel_align_fifo #(
    .DATA_WIDTH (DATA_WIDTH),
    .DEPTH      (FIFO_DEPTH)
  ) u_fifo (
    .clk     (i_CLK),
    .rst_n   (i_RSTn),
    .wr_en   (push_p0),
    .wr_data (i_DATA),
    .rd_en   (pop_p0),
    .rd_data (head_p0),
    .full    (fifo_full_p0),
    .empty   (fifo_empty_p0)
  );

  // Raster position of the pixel about to be popped; advances once per output
  always_ff @(posedge i_CLK or negedge i_RSTn) begin
    if (!i_RSTn) begin
      col_p0 <= '0;
      row_p0 <= '0;
    end else if (pop_p0) begin
      if (col_last_p0) begin
        col_p0 <= '0;
        row_p0 <= row_last_p0 ? '0 : row_p0 + 1'b1;
      end else begin
        col_p0 <= col_p0 + 1'b1;
      end
    end
  end

  // ---- stage p1: registered output pixel and raster markers ----
  // Markers are gated with the pop so they read 0 whenever o_VALID is 0
  always_ff @(posedge i_CLK or negedge i_RSTn) begin
    if (!i_RSTn) begin
      o_VALID <= 1'b0;
      o_DATA  <= '0;
      o_SOL   <= 1'b0;
      o_EOL   <= 1'b0;
      o_EOF   <= 1'b0;
    end else begin
      o_VALID <= pop_p0;
      o_SOL   <= pop_p0 && (col_p0 == '0);
      o_EOL   <= pop_p0 && col_last_p0;
      o_EOF   <= eof_p0;
      if (pop_p0) o_DATA <= composite(i_MASK, head_p0, i_BG_COLOR);
    end
  end

  // Sticky error flags; a new error in the clearing cycle keeps the flag set
  always_ff @(posedge i_CLK or negedge i_RSTn) begin
    if (!i_RSTn) begin
      o_ERR_OVF <= 1'b0;
      o_ERR_UNF <= 1'b0;
    end else begin
      if (ovf_evt_p0)     o_ERR_OVF <= 1'b1;
      else if (i_ERR_CLR) o_ERR_OVF <= 1'b0;
      if (unf_evt_p0)     o_ERR_UNF <= 1'b1;
      else if (i_ERR_CLR) o_ERR_UNF <= 1'b0;
    end
  end

`ifdef FG_COUNT_EN
  localparam int FG_W = $clog2(IMG_WIDTH*IMG_HEIGHT+1);

  logic [FG_W-1:0] fg_run_p0;
  logic [FG_W-1:0] fg_next_p0;

  // The EOF pixel itself is included in the total it publishes
  assign fg_next_p0 = fg_run_p0 + FG_W'(i_MASK);

  // Running foreground count, published and restarted at end of frame
  always_ff @(posedge i_CLK or negedge i_RSTn) begin
    if (!i_RSTn) begin
      fg_run_p0  <= '0;
      o_FG_COUNT <= '0;
    end else if (pop_p0) begin
      if (eof_p0) begin
        o_FG_COUNT <= fg_next_p0;
        fg_run_p0  <= '0;
      end else begin
        fg_run_p0  <= fg_next_p0;
      end
    end
  end
`else
  assign o_FG_COUNT = '0;
`endif

endmodule

// File: tb/tb_mask_compositor.sv
// Bench for mask_compositor on a 4x2 image with an 8-entry FIFO. A reference
// model tracks the pixel queue, raster position, error flags and foreground
// count; expected output pixels go into a scoreboard queue when the mask is
// driven and are popped by a monitor when the DUT emits o_VALID.
module tb_mask_compositor;

  localparam int DW    = 24;
  localparam int DEPTH = 8;
  localparam int W     = 4;
  localparam int H     = 2;
  localparam int FGW   = $clog2(W*H+1);

  logic           clk = 1'b0;
  logic           rst_n;
  logic           i_VALID;
  logic [DW-1:0]  i_DATA;
  logic           i_MASK_VALID;
  logic           i_MASK;
  logic [DW-1:0]  i_BG_COLOR;
  logic           i_ERR_CLR;
  logic           o_VALID;
  logic [DW-1:0]  o_DATA;
  logic           o_SOL;
  logic           o_EOL;
  logic           o_EOF;
  logic           o_ERR_OVF;
  logic           o_ERR_UNF;
  logic [FGW-1:0] o_FG_COUNT;

  always #5 clk = ~clk;

  mask_compositor #(
    .DATA_WIDTH (DW),
    .FIFO_DEPTH (DEPTH),
    .IMG_WIDTH  (W),
    .IMG_HEIGHT (H)
  ) dut (
    .i_CLK        (clk),
    .i_RSTn       (rst_n),
    .i_VALID      (i_VALID),
    .i_DATA       (i_DATA),
    .i_MASK_VALID (i_MASK_VALID),
    .i_MASK       (i_MASK),
    .i_BG_COLOR   (i_BG_COLOR),
    .i_ERR_CLR    (i_ERR_CLR),
    .o_VALID      (o_VALID),
    .o_DATA       (o_DATA),
    .o_SOL        (o_SOL),
    .o_EOL        (o_EOL),
    .o_EOF        (o_EOF),
    .o_ERR_OVF    (o_ERR_OVF),
    .o_ERR_UNF    (o_ERR_UNF),
    .o_FG_COUNT   (o_FG_COUNT)
  );

  typedef struct {
    logic [DW-1:0] d;
    logic          sol;
    logic          eol;
    logic          eof;
  } exp_t;

  exp_t          sb[$];
  logic [DW-1:0] mq[$];
  int            mcol;
  int            mrow;
  logic          m_ovf;
  logic          m_unf;
  int            fg_run;
  int            fg_lat;
  int            total;
  int            bad;
  int            out_cnt;
  int            eof_cnt;

  task automatic model_reset();
    sb.delete();
    mq.delete();
    mcol   = 0;
    mrow   = 0;
    m_ovf  = 1'b0;
    m_unf  = 1'b0;
    fg_run = 0;
    fg_lat = 0;
  endtask

  // Drive one cycle of inputs at the falling edge and advance the model
  task automatic cycle(input logic v, input logic [DW-1:0] d, input logic mv,
                       input logic m, input logic clr, input logic [DW-1:0] bg);
    int            pre;
    logic [DW-1:0] head;
    exp_t          e;
    @(negedge clk);
    i_VALID      = v;
    i_DATA       = d;
    i_MASK_VALID = mv;
    i_MASK       = m;
    i_ERR_CLR    = clr;
    i_BG_COLOR   = bg;
    if (!rst_n) return;
    pre = mq.size();
    if (mv && pre > 0) begin
      head  = mq.pop_front();
      e.d   = m ? head : bg;
      e.sol = (mcol == 0);
      e.eol = (mcol == W-1);
      e.eof = e.eol && (mrow == H-1);
      sb.push_back(e);
      if (e.eof) begin
        fg_lat = fg_run + int'(m);
        fg_run = 0;
      end else begin
        fg_run = fg_run + int'(m);
      end
      if (e.eol) begin
        mcol = 0;
        mrow = (mrow == H-1) ? 0 : mrow + 1;
      end else begin
        mcol = mcol + 1;
      end
    end
    if (v && pre < DEPTH) mq.push_back(d);
    m_ovf = (v && pre >= DEPTH) ? 1'b1 : (clr ? 1'b0 : m_ovf);
    m_unf = (mv && pre == 0)    ? 1'b1 : (clr ? 1'b0 : m_unf);
  endtask

  task automatic idle(input int n);
    repeat (n) cycle(1'b0, '0, 1'b0, 1'b0, 1'b0, '0);
  endtask

  // Scoreboard consumer: runs for the whole simulation, one sample per cycle
  task automatic monitor();
    exp_t           e;
    logic [FGW-1:0] fg_exp;
    forever begin
      @(posedge clk);
      #1;
      total++;
      if (o_VALID === 1'b1) begin
        if (sb.size() == 0) begin
          bad++;
          $display("FAIL unexpected_out: got data=%h, none expected", o_DATA);
        end else begin
          e = sb.pop_front();
          if ({o_DATA, o_SOL, o_EOL, o_EOF} !== {e.d, e.sol, e.eol, e.eof}) begin
            bad++;
            $display("FAIL out_pixel: got data=%h sol/eol/eof=%b%b%b, want data=%h sol/eol/eof=%b%b%b",
                     o_DATA, o_SOL, o_EOL, o_EOF, e.d, e.sol, e.eol, e.eof);
          end
          out_cnt++;
          if (o_EOF === 1'b1) eof_cnt++;
        end
      end else if (sb.size() != 0 || {o_SOL, o_EOL, o_EOF} !== 3'b000) begin
        bad++;
        $display("FAIL idle_cycle: got valid=%b sol/eol/eof=%b%b%b pending=%0d, want valid=%b markers=000",
                 o_VALID, o_SOL, o_EOL, o_EOF, sb.size(), sb.size() != 0);
        sb.delete();
      end
      total++;
      if ({o_ERR_OVF, o_ERR_UNF} !== {m_ovf, m_unf}) begin
        bad++;
        $display("FAIL err_flags: got ovf/unf=%b%b, want %b%b", o_ERR_OVF, o_ERR_UNF, m_ovf, m_unf);
      end
`ifdef FG_COUNT_EN
      fg_exp = FGW'(fg_lat);
`else
      fg_exp = '0;
`endif
      total++;
      if (o_FG_COUNT !== fg_exp) begin
        bad++;
        $display("FAIL fg_count_track: got %0d, want %0d", o_FG_COUNT, fg_exp);
      end
    end
  endtask

  task automatic test_reset();
    repeat (2) @(posedge clk);
    #1;
    total++;
    if ({o_VALID, o_SOL, o_EOL, o_EOF, o_ERR_OVF, o_ERR_UNF} !== 6'b0 ||
        o_DATA !== '0 || o_FG_COUNT !== '0) begin
      bad++;
      $display("FAIL reset_state: got valid=%b data=%h sol/eol/eof=%b%b%b ovf/unf=%b%b fg=%0d, want all 0",
               o_VALID, o_DATA, o_SOL, o_EOL, o_EOF, o_ERR_OVF, o_ERR_UNF, o_FG_COUNT);
    end
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  // Masks 1,0,1,0,... each three cycles behind their pixel
  task automatic test_mask_pattern();
    logic [7:0] pat = 8'b0101_0101;
    int         o0  = out_cnt;
    int         e0  = eof_cnt;
    for (int k = 0; k < 11; k++) begin
      cycle(k < 8, DW'(k + 1), k >= 3, (k >= 3) ? pat[k-3] : 1'b0, 1'b0, 24'hFFFFFF);
    end
    idle(2);
    total++;
    if (out_cnt - o0 != 8 || eof_cnt - e0 != 1) begin
      bad++;
      $display("FAIL pattern_counts: got outs=%0d eofs=%0d, want 8 and 1", out_cnt - o0, eof_cnt - e0);
    end
  endtask

  // Nine pushes into an eight-deep FIFO, then drain; pixel 9 must never appear
  task automatic test_overflow();
    int o0 = out_cnt;
    for (int k = 0; k < 9; k++) cycle(1'b1, DW'(k + 1), 1'b0, 1'b0, 1'b0, 24'h123456);
    @(posedge clk);
    #1;
    total++;
    if (o_ERR_OVF !== 1'b1) begin
      bad++;
      $display("FAIL ovf_set: got %b, want 1", o_ERR_OVF);
    end
    for (int k = 0; k < 8; k++) cycle(1'b0, '0, 1'b1, 1'b1, 1'b0, 24'h123456);
    idle(2);
    total++;
    if (out_cnt - o0 != 8) begin
      bad++;
      $display("FAIL ovf_drain: got outs=%0d, want 8", out_cnt - o0);
    end
  endtask

  task automatic test_underflow();
    cycle(1'b0, '0, 1'b0, 1'b0, 1'b1, '0);
    cycle(1'b0, '0, 1'b1, 1'b1, 1'b0, 24'h00FF00);
    @(posedge clk);
    #1;
    total++;
    if (o_ERR_UNF !== 1'b1 || o_VALID !== 1'b0) begin
      bad++;
      $display("FAIL unf_set: got unf=%b valid=%b, want unf=1 valid=0", o_ERR_UNF, o_VALID);
    end
    // Clear and new underflow together: the set must win
    cycle(1'b0, '0, 1'b1, 1'b0, 1'b1, 24'h00FF00);
    @(posedge clk);
    #1;
    total++;
    if (o_ERR_UNF !== 1'b1) begin
      bad++;
      $display("FAIL unf_set_wins: got %b, want 1", o_ERR_UNF);
    end
    cycle(1'b0, '0, 1'b0, 1'b0, 1'b1, '0);
    @(posedge clk);
    #1;
    total++;
    if (o_ERR_UNF !== 1'b0) begin
      bad++;
      $display("FAIL unf_clear: got %b, want 0", o_ERR_UNF);
    end
    idle(1);
  endtask

  // Push and pop every cycle with a one-cycle lag; background colour varies per pop
  task automatic test_back_to_back();
    int o0 = out_cnt;
    int e0 = eof_cnt;
    for (int k = 0; k < 17; k++) begin
      cycle(k < 16, DW'(24'h000100 + k), k >= 1, (k % 3) != 0, 1'b0, DW'(24'hA00000 + k));
    end
    idle(2);
    total++;
    if (out_cnt - o0 != 16 || eof_cnt - e0 != 2 || {o_ERR_OVF, o_ERR_UNF} !== 2'b00) begin
      bad++;
      $display("FAIL b2b_summary: got outs=%0d eofs=%0d ovf/unf=%b%b, want 16, 2, 00",
               out_cnt - o0, eof_cnt - e0, o_ERR_OVF, o_ERR_UNF);
    end
  endtask

  task automatic test_reset_midframe();
    int o0  = out_cnt;
    int e0;
    bit hit = 1'b0;
    for (int k = 0; k < 12; k++) begin
      cycle(k < 8, DW'(24'h000200 + k), k >= 2 && k < 10, 1'b1, 1'b0, 24'h0000FF);
      @(posedge clk);
      #2;
      if (out_cnt - o0 == 3) begin
        hit = 1'b1;
        break;
      end
    end
    total++;
    if (!hit) begin
      bad++;
      $display("FAIL midreset_wait: got outs=%0d, want 3 within budget", out_cnt - o0);
    end
    rst_n = 1'b0;
    model_reset();
    #1;
    total++;
    if ({o_VALID, o_SOL, o_EOL, o_EOF, o_ERR_OVF, o_ERR_UNF} !== 6'b0 ||
        o_DATA !== '0 || o_FG_COUNT !== '0) begin
      bad++;
      $display("FAIL midreset_outputs: got valid=%b data=%h flags=%b%b%b%b%b fg=%0d, want all 0",
               o_VALID, o_DATA, o_SOL, o_EOL, o_EOF, o_ERR_OVF, o_ERR_UNF, o_FG_COUNT);
    end
    idle(2);
    @(negedge clk);
    rst_n = 1'b1;
    o0 = out_cnt;
    e0 = eof_cnt;
    for (int k = 0; k < 9; k++) cycle(k < 8, DW'(24'h000300 + k), k >= 1, (k % 2) == 1, 1'b0, 24'h0F0F0F);
    idle(2);
    total++;
    if (out_cnt - o0 != 8 || eof_cnt - e0 != 1) begin
      bad++;
      $display("FAIL midreset_frame: got outs=%0d eofs=%0d, want 8 and 1", out_cnt - o0, eof_cnt - e0);
    end
  endtask

  // Frame of 5 foreground / 3 background, then an all-foreground frame
  task automatic test_fg_count();
    logic [7:0] pat [2];
    int         want [2];
    pat[0] = 8'b0110_1011;
    pat[1] = 8'b1111_1111;
`ifdef FG_COUNT_EN
    want[0] = 5;
    want[1] = 8;
`else
    want[0] = 0;
    want[1] = 0;
`endif
    for (int f = 0; f < 2; f++) begin
      for (int k = 0; k < 9; k++) begin
        cycle(k < 8, DW'(24'h000400 + k), k >= 1, (k >= 1) ? pat[f][k-1] : 1'b0, 1'b0, 24'h222222);
      end
      idle(1);
      total++;
      if (o_FG_COUNT !== FGW'(want[f])) begin
        bad++;
        $display("FAIL fg_frame%0d: got %0d, want %0d", f, o_FG_COUNT, want[f]);
      end
      idle(1);
    end
  endtask

  initial begin
    rst_n        = 1'b0;
    i_VALID      = 1'b0;
    i_DATA       = '0;
    i_MASK_VALID = 1'b0;
    i_MASK       = 1'b0;
    i_BG_COLOR   = '0;
    i_ERR_CLR    = 1'b0;
    total        = 0;
    bad          = 0;
    out_cnt      = 0;
    eof_cnt      = 0;
    model_reset();
    fork
      monitor();
    join_none
    test_reset();
    test_mask_pattern();
    test_overflow();
    test_underflow();
    test_back_to_back();
    test_reset_midframe();
    test_fg_count();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
